// File: rtl/alu_arbiter.sv
// Two-client arbiter/sequencer for the shared registered ALU: one operation in flight, result returned per client.
// Build option: define ALU_ARB_RR_EN for round-robin grant; otherwise fixed priority with client 0 winning ties.
//
// state   | meaning
// IDLE    | waiting for a request; winner's ready asserted combinationally
// BUSY    | ALU inputs held, cnt counts down the ALU latency
// RESP    | result held on rsp_data, waiting for the granted client's rsp_ready
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in0,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [2:0]       req0_opcode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in0,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [2:0]       req1_opcode,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_overflow,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       grant_id;
    logic       last;
    logic       sel;
    logic       accept;
    logic       capture;
    logic       rsp_done;
    logic       rsp_ready_sel;

`ifdef ALU_ARB_RR_EN
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end
`else
    // last is kept up to date so both builds share one datapath; only round-robin reads it
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        sel = ~req0_valid;
    end
`endif

    assign rsp_ready_sel = grant_id ? rsp1_ready : rsp0_ready;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                // requests are never granted while reset is asserted
                if (!rst && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~sel;
                    req1_ready = sel;
                    state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp0_valid = ~grant_id;
                rsp1_valid = grant_id;
                if (rsp_ready_sel) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 4'd0;
            grant_id     <= 1'b0;
            last         <= 1'b1;
            alu_in0      <= '0;
            alu_in1      <= '0;
            alu_opcode   <= 3'd0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            if (accept) begin
                grant_id   <= sel;
                cnt        <= LAT_CNT;
                alu_in0    <= sel ? req1_in0 : req0_in0;
                alu_in1    <= sel ? req1_in1 : req0_in1;
                alu_opcode <= sel ? req1_opcode : req0_opcode;
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_data     <= alu_out;
                rsp_overflow <= alu_overflow;
            end
            if (rsp_done) begin
                last <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a registered-adder ALU stub (LAT = 1).
// Expected contention order follows ALU_ARB_RR_EN when the bench is built with it.
module tb_alu_arbiter;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_in0, req0_in1, req1_in0, req1_in1;
    logic [2:0]       req0_opcode, req1_opcode;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_overflow;
    logic [WIDTH-1:0] alu_in0, alu_in1;
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_out;
    logic             alu_overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        {alu_overflow, alu_out} <= {1'b0, alu_in0} + {1'b0, alu_in1};
    end

    alu_arbiter #(.WIDTH(WIDTH), .LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in0(req0_in0), .req0_in1(req0_in1), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in0(req1_in0), .req1_in1(req1_in1), .req1_opcode(req1_opcode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [70:0] outs;
        rst = 1'b1;
        req0_valid = 1'b1; req0_in0 = 16'd4; req0_in1 = 16'd20; req0_opcode = 3'd5;
        req1_valid = 1'b1; req1_in0 = 16'd7; req1_in1 = 16'd9;  req1_opcode = 3'd6;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_in0, alu_in1,
                    alu_opcode, rsp_data, rsp_overflow};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn_ignored busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req0_valid = 1'b1; req0_in0 = 16'd4; req0_in1 = 16'd20; req0_opcode = 3'd0;
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got %b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({alu_in0, alu_in1, alu_opcode, busy} !== {16'd4, 16'd20, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_alu_inputs: got %0d %0d %0d busy %b expected 4 20 0 busy 1",
                     alu_in0, alu_in1, alu_opcode, busy);
        end
        for (int c = 2; c <= 4; c++) begin
            if (c > 2) step(); else step();
            checks++;
            if (rsp1_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_rsp1_quiet T+%0d: got %b expected 0", c, rsp1_valid);
            end
            checks++;
            if (rsp0_valid !== (c == 3)) begin
                errors++;
                $display("FAIL single_rsp0_valid T+%0d: got %b expected %b", c, rsp0_valid, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if ({rsp_data, rsp_overflow} !== {16'd24, 1'b0}) begin
                    errors++;
                    $display("FAIL single_result: got %0d ovf %b expected 24 ovf 0", rsp_data, rsp_overflow);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_back_idle busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        req1_valid = 1'b1; req1_in0 = 16'hFFFF; req1_in1 = 16'h0002; req1_opcode = 3'd0;
        rsp1_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_accept: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        step();
        step();
        checks++;
        if ({rsp1_valid, rsp0_valid, rsp_data, rsp_overflow} !== {1'b1, 1'b0, 16'h0001, 1'b1}) begin
            errors++;
            $display("FAIL ovf_result: got v1 %b v0 %b data %h ovf %b expected v1 1 v0 0 data 0001 ovf 1",
                     rsp1_valid, rsp0_valid, rsp_data, rsp_overflow);
        end
        step();
    endtask

    task automatic test_contention();
        logic [3:0] exp_order;
        int n = 0;
        int last_c = 0;
`ifdef ALU_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_in0 = 16'd100; req0_in1 = 16'd1; req0_opcode = 3'd0;
        req1_in0 = 16'd200; req1_in1 = 16'd2; req1_opcode = 3'd0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (n >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else begin
                req0_valid = 1'b1;
                req1_valid = 1'b1;
            end
            #1;
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL cont_both_ready cycle %0d: got 11 expected at most one", c);
            end
            if (req0_ready || req1_ready) begin
                checks++;
                if (req1_ready !== exp_order[n]) begin
                    errors++;
                    $display("FAIL cont_grant_%0d: got client %0d expected client %0d", n, req1_ready, exp_order[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (c - last_c !== 4) begin
                        errors++;
                        $display("FAIL cont_issue_interval: got %0d expected 4", c - last_c);
                    end
                end
                last_c = c;
                n++;
            end
            if (rsp0_valid) begin
                checks++;
                if (rsp_data !== 16'd101) begin
                    errors++;
                    $display("FAIL cont_rsp0_data: got %0d expected 101", rsp_data);
                end
            end
            if (rsp1_valid) begin
                checks++;
                if (rsp_data !== 16'd202) begin
                    errors++;
                    $display("FAIL cont_rsp1_data: got %0d expected 202", rsp_data);
                end
            end
        end
        checks++;
        if (n !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_grant_count: got %0d grants busy %b expected 4 grants busy 0", n, busy);
        end
    endtask

    task automatic test_backpressure();
        int waited = 0;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_in0 = 16'd7; req0_in1 = 16'd8; req0_opcode = 3'd0;
        #1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_in0 = 16'd3; req1_in1 = 16'd4; req1_opcode = 3'd0;
        #1;
        while (rsp0_valid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++;
        if (rsp0_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_rsp0_timeout: got %b expected 1", rsp0_valid);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp0_valid, rsp_data, busy, req1_ready} !== {1'b1, 16'd15, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got v0 %b data %0d busy %b r1 %b expected v0 1 data 15 busy 1 r1 0",
                         i, rsp0_valid, rsp_data, busy, req1_ready);
            end
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake_r1: got %b expected 0", req1_ready);
        end
        step();
        checks++;
        if ({rsp0_valid, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_next_accept: got v0 %b r1 %b expected v0 0 r1 1", rsp0_valid, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        rsp1_ready = 1'b1;
        #1;
        step();
        step();
        checks++;
        if ({rsp1_valid, rsp_data} !== {1'b1, 16'd7}) begin
            errors++;
            $display("FAIL bp_req1_result: got v1 %b data %0d expected v1 1 data 7", rsp1_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_abort();
        int seen = 0;
        @(negedge clk);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_in0 = 16'd9; req0_in1 = 16'd9; req0_opcode = 3'd2;
        #1;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({busy, alu_in0, alu_opcode, rsp_data, rsp0_valid} !== '0) begin
            errors++;
            $display("FAIL abort_cleared: got busy %b in0 %0d op %0d data %0d v0 %b expected all 0",
                     busy, alu_in0, alu_opcode, rsp_data, rsp0_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp0_valid || rsp1_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_response: got %0d valid cycles expected 0", seen);
        end
        @(negedge clk);
        req1_valid = 1'b1; req1_in0 = 16'd5; req1_in1 = 16'd6; req1_opcode = 3'd0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_accept: got %b expected 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        step();
        step();
        checks++;
        if ({rsp1_valid, rsp_data, rsp_overflow} !== {1'b1, 16'd11, 1'b0}) begin
            errors++;
            $display("FAIL abort_next_result: got v1 %b data %0d ovf %b expected v1 1 data 11 ovf 0",
                     rsp1_valid, rsp_data, rsp_overflow);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_overflow();
        test_contention();
        test_backpressure();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
